aes_key_loader: RTL

// - Initiator/consumer side of the Peripheral Key Table (PKT) lookup.
// - Takes a peripheral key id from the AES front-end and drives it to the PKT.
// - Checks the returned ROM2 key location, then reads KEY_WORDS 32-bit words from ROM2.
// - Delivers the assembled key to the AES core over a valid/ready handshake, then scrubs it.

---
 rtl/aes_key_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes_key_loader.sv
// aes_key_loader: resolves a peripheral key id through the PKT, reads the key
// words from ROM2 with pipelined requests, hands the key to the AES core over
// valid/ready and scrubs it once accepted.
module aes_key_loader #(
  parameter int unsigned KEY_WORDS   = 4,
  parameter int unsigned PKT_LAT     = 2,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned NUM_KEYS    = 6,
  parameter logic [31:0] INVALID_LOC = 32'hFFFF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               key_id_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [KEY_WORDS*32-1:0]   key_o,
  output logic                      key_valid_o,
  input  logic                      key_ready_i,
  output logic                      pkt_req_o,
  output logic [31:0]               pkt_index_o,
  input  logic [31:0]               pkt_loc_i,
  output logic                      rom_req_o,
  output logic [31:0]               rom_addr_o,
  input  logic [31:0]               rom_rdata_i
);

  localparam int unsigned KEY_W = KEY_WORDS * 32;
  localparam int unsigned CNT_W = $clog2(KEY_WORDS + 1);
  localparam int unsigned LAT_W = (PKT_LAT > 1) ? $clog2(PKT_LAT) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PKT_WAIT = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_DELIVER  = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [LAT_W-1:0]   r_wait_cnt;
  logic [31:0]        r_loc;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_cap_cnt;
  logic [ROM_LAT-1:0] r_rd_pipe;
  logic [KEY_W-1:0]   r_key;
  logic               r_key_valid;
  logic               r_busy;
  logic               r_err;
  logic               r_pkt_req;
  logic [31:0]        r_pkt_index;
  logic               r_rom_req;
  logic [31:0]        r_rom_addr;

  logic w_loc_bad;
  logic w_wait_done;
  logic w_capture;
  logic w_last_cap;
  logic w_handshake;

  assign w_loc_bad   = (r_loc == INVALID_LOC) || (r_loc >= 32'(NUM_KEYS));
  assign w_wait_done = (r_wait_cnt == LAT_W'(PKT_LAT - 1));
  assign w_capture   = r_rd_pipe[ROM_LAT-1] && (r_state == S_FETCH);
  assign w_last_cap  = w_capture && (r_cap_cnt == CNT_W'(KEY_WORDS - 1));
  assign w_handshake = (r_state == S_DELIVER) && r_key_valid && key_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (req_i)       w_next_state = S_PKT_WAIT;
      S_PKT_WAIT: if (w_wait_done) w_next_state = S_CHECK;
      S_CHECK:    w_next_state = w_loc_bad ? S_ERROR : S_FETCH;
      S_FETCH:    if (w_last_cap)  w_next_state = S_DELIVER;
      S_DELIVER:  if (w_handshake) w_next_state = S_IDLE;
      S_ERROR:    w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Status flags and PKT lookup interface
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_key_valid <= 1'b0;
      r_pkt_req   <= 1'b0;
      r_pkt_index <= '1;
      r_wait_cnt  <= '0;
      r_loc       <= '0;
    end else begin
      r_busy      <= (w_next_state != S_IDLE);
      r_err       <= (w_next_state == S_ERROR);
      r_key_valid <= (w_next_state == S_DELIVER);
      r_pkt_req   <= (w_next_state == S_PKT_WAIT);
      if ((r_state == S_IDLE) && req_i) r_pkt_index <= key_id_i;
      else if (w_next_state == S_IDLE)  r_pkt_index <= '1;
      if (r_state == S_PKT_WAIT) r_wait_cnt <= r_wait_cnt + LAT_W'(1);
      else                       r_wait_cnt <= '0;
      if ((r_state == S_PKT_WAIT) && w_wait_done) r_loc <= pkt_loc_i;
    end
  end

  // ROM2 request issue and read-latency tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rom_req  <= 1'b0;
      r_rom_addr <= '0;
      r_req_cnt  <= '0;
      r_rd_pipe  <= '0;
    end else begin
      r_rd_pipe <= ROM_LAT'({r_rd_pipe, r_rom_req});
      if ((r_state == S_CHECK) && !w_loc_bad) begin
        r_rom_req  <= 1'b1;
        r_rom_addr <= r_loc * 32'(KEY_WORDS);
        r_req_cnt  <= CNT_W'(1);
      end else if ((r_state == S_FETCH) && (r_req_cnt < CNT_W'(KEY_WORDS))) begin
        r_rom_req  <= 1'b1;
        r_rom_addr <= r_rom_addr + 32'd1;
        r_req_cnt  <= r_req_cnt + CNT_W'(1);
      end else begin
        r_rom_req  <= 1'b0;
      end
    end
  end

  // Key assembly from returning read data; scrub after handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_key     <= '0;
      r_cap_cnt <= '0;
    end else begin
      if (r_state == S_CHECK) r_cap_cnt <= '0;
      else if (w_capture)     r_cap_cnt <= r_cap_cnt + CNT_W'(1);
      if (w_handshake) begin
        r_key <= '0;
      end else if (w_capture) begin
        for (int i = 0; i < int'(KEY_WORDS); i++) begin
          if (r_cap_cnt == CNT_W'(i)) r_key[32*i +: 32] <= rom_rdata_i;
        end
      end
    end
  end

  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign key_o       = r_key;
  assign key_valid_o = r_key_valid;
  assign pkt_req_o   = r_pkt_req;
  assign pkt_index_o = r_pkt_index;
  assign rom_req_o   = r_rom_req;
  assign rom_addr_o  = r_rom_addr;

endmodule
